// File: rtl/input_quant_packer.sv
// Quantises raw features to 2-bit codes and packs NUM_FEAT of them into one vector.
// Latency: m_valid rises 1 cycle after the closing beat is accepted.
// Backpressure: s_ready follows m_ready while a vector is held, so a new beat can land in the handoff cycle.
module input_quant_packer #(
    parameter int          NUM_FEAT = 3,
    parameter int          IN_W     = 8,
    parameter int unsigned T0       = 64,
    parameter int unsigned T1       = 128,
    parameter int unsigned T2       = 192
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [IN_W-1:0]       s_data,
    input  logic                  s_last,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [2*NUM_FEAT-1:0] m_data,
    output logic                  err,
    output logic [15:0]           vec_cnt
);

    localparam int IDX_W = $clog2(NUM_FEAT + 1);
    localparam logic [IN_W:0] T0_L = (IN_W + 1)'(T0);
    localparam logic [IN_W:0] T1_L = (IN_W + 1)'(T1);
    localparam logic [IN_W:0] T2_L = (IN_W + 1)'(T2);

    typedef enum logic {FILL, HOLD} state_t;

    state_t                state_q, state_nxt;
    logic [IDX_W-1:0]      idx_q, idx_nxt;
    logic [2*NUM_FEAT-1:0] data_q, data_nxt;
    logic                  err_q, err_nxt;
    logic [15:0]           cnt_q, cnt_nxt;

    logic [2*NUM_FEAT-1:0] beat_base;
    logic [IDX_W-1:0]      beat_idx;
    logic                  last_slot;
    logic                  accept;

    function automatic logic [1:0] quant(input logic [IN_W-1:0] x);
        logic [IN_W:0] xe;
        xe = {1'b0, x};
        if (xe < T0_L)      return 2'd0;
        else if (xe < T1_L) return 2'd1;
        else if (xe < T2_L) return 2'd2;
        else                return 2'd3;
    endfunction

    assign s_ready = rst && ((state_q == FILL) || m_ready);
    assign accept  = s_valid && s_ready;
    assign m_valid = (state_q == HOLD);
    assign m_data  = data_q;
    assign err     = err_q;
    assign vec_cnt = cnt_q;

    always_comb begin
        state_nxt = state_q;
        idx_nxt   = idx_q;
        data_nxt  = data_q;
        err_nxt   = err_q;
        cnt_nxt   = cnt_q;
        beat_base = data_q;
        beat_idx  = idx_q;
        last_slot = 1'b0;

        // Handoff empties the vector; a concurrent beat then starts the next one at slot 0.
        if (state_q == HOLD && m_ready) begin
            cnt_nxt   = cnt_q + 16'd1;
            state_nxt = FILL;
            idx_nxt   = '0;
            data_nxt  = '0;
            beat_base = '0;
            beat_idx  = '0;
        end

        if (accept) begin
            last_slot = (beat_idx == IDX_W'(NUM_FEAT - 1));
            data_nxt  = beat_base;
            data_nxt[2*int'(beat_idx) +: 2] = quant(s_data);
            idx_nxt   = beat_idx + IDX_W'(1);
            if (s_last || last_slot)
                state_nxt = HOLD;
            // Framing is only clean when s_last coincides with the final slot.
            if (s_last != last_slot)
                err_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FILL;
            idx_q   <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
            cnt_q   <= 16'd0;
        end else begin
            state_q <= state_nxt;
            idx_q   <= idx_nxt;
            data_q  <= data_nxt;
            err_q   <= err_nxt;
            cnt_q   <= cnt_nxt;
        end
    end

endmodule

// File: tb/tb_input_quant_packer.sv
// Directed bench for input_quant_packer: table of clean vectors plus hand-written corner sequences.
module tb_input_quant_packer;

    logic        clk = 1'b0;
    logic        rst;
    logic        s_valid;
    logic        s_ready;
    logic [7:0]  s_data;
    logic        s_last;
    logic        m_valid;
    logic        m_ready;
    logic [5:0]  m_data;
    logic        err;
    logic [15:0] vec_cnt;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    input_quant_packer dut (
        .clk     (clk),
        .rst     (rst),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .s_data  (s_data),
        .s_last  (s_last),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .err     (err),
        .vec_cnt (vec_cnt)
    );

    typedef struct {
        logic [7:0] d0;
        logic [7:0] d1;
        logic [7:0] d2;
        logic [5:0] exp;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] d, input logic l);
        s_valid = 1'b1;
        s_data  = d;
        s_last  = l;
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c, input logic l);
        send(a, 1'b0);
        send(b, 1'b0);
        send(c, l);
    endtask

    task automatic handoff(input logic [15:0] exp_cnt);
        m_ready = 1'b1;
        step();
        chk("handoff_mvalid", 32'(m_valid), 0);
        chk("handoff_cnt", 32'(vec_cnt), 32'(exp_cnt));
        m_ready = 1'b0;
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{8'd10,  8'd100, 8'd200, 6'b110100};
        tbl[1] = '{8'd63,  8'd64,  8'd255, 6'b110100};
        tbl[2] = '{8'd0,   8'd127, 8'd128, 6'b100100};
        tbl[3] = '{8'd191, 8'd192, 8'd64,  6'b011110};
        tbl[4] = '{8'd255, 8'd255, 8'd255, 6'b111111};
        tbl[5] = '{8'd0,   8'd0,   8'd0,   6'b000000};

        rst = 1'b0; s_valid = 1'b0; s_data = 8'd0; s_last = 1'b0; m_ready = 1'b0;
        repeat (2) step();
        chk("rst_sready", 32'(s_ready), 0);
        chk("rst_mvalid", 32'(m_valid), 0);
        chk("rst_cnt", 32'(vec_cnt), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_mdata", 32'(m_data), 0);
        rst = 1'b1;
        step();
        chk("post_rst_sready", 32'(s_ready), 1);

        for (int i = 0; i < 6; i++) begin
            send3(tbl[i].d0, tbl[i].d1, tbl[i].d2, 1'b1);
            chk("tbl_mvalid", 32'(m_valid), 1);
            chk("tbl_mdata", 32'(m_data), 32'(tbl[i].exp));
            chk("tbl_sready_hold", 32'(s_ready), 0);
            chk("tbl_err", 32'(err), 0);
            handoff(16'(i + 1));
        end

        // Stalled HOLD with a pending beat, then handoff with a concurrent beat.
        send3(8'd10, 8'd100, 8'd200, 1'b1);
        s_valid = 1'b1; s_data = 8'd17; s_last = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step();
            chk("stall_sready", 32'(s_ready), 0);
            chk("stall_mvalid", 32'(m_valid), 1);
            chk("stall_mdata", 32'(m_data), 32'(6'b110100));
        end
        m_ready = 1'b1; s_data = 8'd255;
        step();
        chk("concur_mvalid", 32'(m_valid), 0);
        chk("concur_cnt", 32'(vec_cnt), 7);
        s_data = 8'd0;
        step();
        s_last = 1'b1;
        step();
        s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;
        chk("concur_next_mvalid", 32'(m_valid), 1);
        chk("concur_next_mdata", 32'(m_data), 32'(6'b000011));
        handoff(16'd8);

        // Idle s_valid mid-vector must not advance anything.
        send(8'd255, 1'b0);
        for (int k = 0; k < 4; k++) begin
            step();
            chk("fill_stall_mvalid", 32'(m_valid), 0);
            chk("fill_stall_sready", 32'(s_ready), 1);
        end
        send(8'd64, 1'b0);
        send(8'd191, 1'b1);
        chk("fill_stall_mdata", 32'(m_data), 32'(6'b100111));
        handoff(16'd9);

        // Early s_last; err must stick across a later clean vector.
        send(8'd150, 1'b1);
        chk("early_mvalid", 32'(m_valid), 1);
        chk("early_mdata", 32'(m_data), 32'(6'b000010));
        chk("early_err", 32'(err), 1);
        handoff(16'd10);
        send3(8'd10, 8'd100, 8'd200, 1'b1);
        chk("sticky_mdata", 32'(m_data), 32'(6'b110100));
        chk("sticky_err", 32'(err), 1);
        handoff(16'd11);

        // Reset in the middle of a vector discards it.
        send(8'd255, 1'b0);
        send(8'd255, 1'b0);
        rst = 1'b0;
        step();
        chk("midrst_sready", 32'(s_ready), 0);
        chk("midrst_mvalid", 32'(m_valid), 0);
        chk("midrst_cnt", 32'(vec_cnt), 0);
        chk("midrst_err", 32'(err), 0);
        rst = 1'b1;
        step();
        send3(8'd200, 8'd200, 8'd10, 1'b1);
        chk("midrst_next_mvalid", 32'(m_valid), 1);
        chk("midrst_next_mdata", 32'(m_data), 32'(6'b001111));
        chk("midrst_next_err", 32'(err), 0);
        handoff(16'd1);

        // Missing s_last on the final slot still closes the vector but flags err.
        send3(8'd10, 8'd100, 8'd200, 1'b0);
        chk("nolast_mvalid", 32'(m_valid), 1);
        chk("nolast_mdata", 32'(m_data), 32'(6'b110100));
        chk("nolast_err", 32'(err), 1);
        handoff(16'd2);

        // Counter wrap: single-beat vectors streamed back to back.
        rst = 1'b0;
        step();
        rst = 1'b1;
        step();
        s_valid = 1'b1; s_data = 8'd200; s_last = 1'b1; m_ready = 1'b1;
        repeat (65536) @(posedge clk);
        #1;
        chk("wrap_ffff", 32'(vec_cnt), 32'h0000_ffff);
        chk("wrap_mdata", 32'(m_data), 32'(6'b000011));
        step();
        chk("wrap_zero", 32'(vec_cnt), 0);
        s_valid = 1'b0; s_last = 1'b0; m_ready = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/input_quant_packer.md
INPUT_QUANT_PACKER -- requirements
Module: input_quant_packer

Interface
REQ-001 SHALL have parameter NUM_FEAT, default 3, giving the number of features per packed vector.
REQ-002 SHALL have parameter IN_W, default 8, giving the raw feature width (unsigned).
REQ-003 SHALL have parameters T0, T1, T2, defaults 64, 128, 192, giving quantisation thresholds; T0<T1<T2 is required.
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port rst, input, 1 bit: reset, synchronous and active-low.
REQ-006 SHALL have port s_valid, input, 1 bit: raw feature valid.
REQ-007 SHALL have port s_ready, output, 1 bit: raw feature accepted when s_valid and s_ready are both high.
REQ-008 SHALL have port s_data, input, IN_W bits: raw feature value.
REQ-009 SHALL have port s_last, input, 1 bit: marks the last feature of a vector.
REQ-010 SHALL have port m_valid, output, 1 bit: packed vector valid, driving the layer0 neuron inputs.
REQ-011 SHALL have port m_ready, input, 1 bit: downstream accepts the vector.
REQ-012 SHALL have port m_data, output, 2*NUM_FEAT bits: packed 2-bit codes; feature i occupies bits [2i+1:2i].
REQ-013 SHALL have port err, output, 1 bit: sticky framing error flag.
REQ-014 SHALL have port vec_cnt, output, 16 bits: count of vectors handed off.

Function
REQ-015 SHALL quantise each accepted feature x as follows: code 0 if x<T0, 1 if x<T1, 2 if x<T2, else 3.
REQ-016 SHALL implement two states, FILL and HOLD; the reset state is FILL.
REQ-017 In FILL, SHALL drive s_ready=1 and m_valid=0, and on each accepted beat write the code into slot idx and increment idx.
REQ-018 SHALL transition FILL->HOLD on acceptance of a beat with s_last=1, or of a beat with idx==NUM_FEAT-1, whichever occurs first.
REQ-019 In HOLD, SHALL drive m_valid=1 and hold m_data stable until the handshake m_valid&&m_ready completes.
REQ-020 In HOLD, SHALL drive s_ready=m_ready; a beat accepted in the handoff cycle becomes slot 0 of the next vector, with idx set to 1 and the state returning to FILL.
REQ-021 On handoff with no concurrent beat accepted, SHALL clear all slots to 0, set idx to 0, and enter FILL.
REQ-022 SHALL set m_valid exactly one cycle after the closing beat is accepted, giving a latency of 1 cycle.
REQ-023 Early s_last (idx<NUM_FEAT-1): unfilled slots SHALL stay 0, the vector SHALL be emitted, and err SHALL be set.
REQ-024 Missing s_last (beat with idx==NUM_FEAT-1 and s_last=0): the vector SHALL be emitted and err SHALL be set.
REQ-025 Once set, err SHALL remain 1 until reset.
REQ-026 SHALL increment vec_cnt by 1 on each m handshake, wrapping from 0xFFFF to 0.
REQ-027 s_valid=0 SHALL stall FILL indefinitely with no state change; m_ready=0 SHALL stall HOLD indefinitely.
REQ-028 An s_valid=1 beat while s_ready=0 SHALL NOT be consumed; it is held upstream.

Reset
REQ-029 With rst=0 at a clk edge, the block SHALL set state=FILL, idx=0, all slots=0, m_valid=0, err=0, vec_cnt=0; s_ready SHALL be 0 while rst=0.
REQ-030 Reset asserted mid-vector or in HOLD SHALL discard the partial or pending vector, with no handshake counted.

Verification
REQ-031 Scenario: with the defaults, stream 10, 100, 200 (s_last on 200) with m_ready=1 -> one cycle later m_valid=1, m_data=6'b110100, err=0, and vec_cnt=1 after the handshake.
REQ-032 Scenario: stream 63, 64, 255 with s_last on 255 -> m_data=6'b110100; thresholds are inclusive at the lower bound (64 yields code 1).
REQ-033 Scenario: stream 150 with s_last=1 on the first beat -> m_data=6'b000010, err=1, and err stays 1 across subsequent good vectors.
REQ-034 Scenario: hold m_ready=0 for 5 cycles in HOLD while s_valid=1 -> s_ready=0 and m_data stable; raise m_ready together with s_data=255 -> handoff, and the next vector has slot0=3 with idx=1.
REQ-035 Scenario: drive 65536 back-to-back vectors -> vec_cnt wraps to 0.
REQ-036 Scenario: assert rst=0 after 2 beats of a vector -> m_valid=0, idx=0, and the next 3 beats form a clean vector.
